// File: rtl/tpiu_trace_tx_pkg.sv
// Shared definitions for the TPIU trace transmitter: FSM states, sync and
// pad byte values, frame geometry and the data-byte encoding rule.
package tpiu_trace_tx_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_FRAME = 2'd1,
    ST_PAD   = 2'd2
  } tpiu_state_e;

  // Full sync packet is FF FF FF 7F.
  localparam logic [7:0] SYNC_BYTE      = 8'hFF;
  localparam logic [7:0] SYNC_LAST_BYTE = 8'h7F;
  localparam logic [3:0] SYNC_LAST_IDX  = 4'd3;

  // Pad bytes: null ID change on even slots, zero on odd slots.
  localparam logic [7:0] PAD_EVEN = 8'h01;
  localparam logic [7:0] PAD_ODD  = 8'h00;

  // Frame geometry: byte 0 is the ID change, 1..14 data, 15 the aux byte.
  localparam int         FRAME_LEN     = 16;
  localparam logic [3:0] AUX_IDX       = 4'(FRAME_LEN - 1);
  localparam logic [3:0] LAST_DATA_IDX = AUX_IDX - 4'd1;

  // Odd slots carry the byte verbatim; even slots drop bit 0, which
  // travels in the aux byte instead.
  function automatic logic [7:0] encode_data(input logic [3:0] slot,
                                             input logic [7:0] d);
    return slot[0] ? d : {d[7:1], 1'b0};
  endfunction

endpackage

// File: rtl/tpiu_nibble_ser.sv
// Byte-to-nibble serializer: a loaded byte goes out low nibble first,
// high nibble on the following cycle. last_nibble marks the high nibble.
module tpiu_nibble_ser (
  input  logic       trace_clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic [3:0] nibble,
  output logic       last_nibble
);

  logic [3:0] nibble_q;
  logic [3:0] high_q;
  logic       last_q;

  // Reset shows the first nibble of an FF sync byte with F still pending.
  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      nibble_q <= 4'hF;
      high_q   <= 4'hF;
      last_q   <= 1'b0;
    end else if (load) begin
      nibble_q <= byte_in[3:0];
      high_q   <= byte_in[7:4];
      last_q   <= 1'b0;
    end else begin
      nibble_q <= high_q;
      last_q   <= 1'b1;
    end
  end

  assign nibble      = nibble_q;
  assign last_nibble = last_q;

endmodule

// File: rtl/tpiu_trace_tx.sv
// TPIU formatter transmitter: packs a byte stream into 16-byte frames with
// periodic full-sync packets and drives them one nibble per clock.
// Handshake: a byte moves when I_valid & O_ready at a rising edge; O_ready is
// a pure function of the current state and never looks at I_valid, while
// I_valid may be raised or dropped freely (a drop at a data slot pads out the
// rest of the frame).
module tpiu_trace_tx
  import tpiu_trace_tx_pkg::*;
#(
  parameter int pSYNC_FRAMES = 8
) (
  input  logic        trace_clk,
  input  logic        reset,
  input  logic [6:0]  I_id,
  input  logic [7:0]  I_data,
  input  logic        I_valid,
  output logic        O_ready,
  output logic [3:0]  O_tracedata,
  output logic        O_sync_active,
  output logic        O_frame_active,
  output logic [15:0] O_frame_count
);

  // State, byte index and flags describe the nibble currently on O_tracedata.
  tpiu_state_e state_q, state_d;
  logic [3:0]  byte_idx_q, byte_idx_d, next_idx;
  logic [7:0]  aux_q, aux_d;
  logic [7:0]  interval_q, interval_d;
  logic [15:0] count_q, count_d;
  logic        sync_active_q, frame_active_q;
  logic        load, last_nibble, start_frame, start_sync;
  logic [7:0]  load_byte;

  // Next data slot may be taken only from an unpadded frame, on the high
  // nibble of the slot before it.
  assign O_ready = (state_q == ST_FRAME) && last_nibble && (byte_idx_q < LAST_DATA_IDX);

  // Next-state and next-byte selection; every decision sits on a high nibble.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    aux_d       = aux_q;
    interval_d  = interval_q;
    count_d     = count_q;
    load        = 1'b0;
    load_byte   = SYNC_BYTE;
    start_frame = 1'b0;
    start_sync  = 1'b0;
    next_idx    = byte_idx_q + 4'd1;
    if (last_nibble) begin
      load = 1'b1;
      case (state_q)
        ST_SYNC: begin
          if (byte_idx_q == SYNC_LAST_IDX) begin
            if (I_valid) start_frame = 1'b1;
            else         start_sync  = 1'b1;
          end else begin
            byte_idx_d = next_idx;
            load_byte  = (next_idx == SYNC_LAST_IDX) ? SYNC_LAST_BYTE : SYNC_BYTE;
          end
        end
        ST_FRAME, ST_PAD: begin
          if (byte_idx_q == AUX_IDX) begin
            count_d = count_q + 16'd1;
            if (interval_q >= 8'(pSYNC_FRAMES - 1)) begin
              start_sync = 1'b1;
            end else if (I_valid) begin
              start_frame = 1'b1;
              interval_d  = interval_q + 8'd1;
            end else begin
              start_sync = 1'b1;
            end
          end else if (byte_idx_q == LAST_DATA_IDX) begin
            byte_idx_d = AUX_IDX;
            load_byte  = aux_q;
          end else begin
            byte_idx_d = next_idx;
            if (O_ready && I_valid) begin
              load_byte = encode_data(next_idx, I_data);
              if (!next_idx[0]) aux_d[next_idx[3:1]] = I_data[0];
            end else begin
              state_d   = ST_PAD;
              load_byte = next_idx[0] ? PAD_ODD : PAD_EVEN;
            end
          end
        end
        default: start_sync = 1'b1;
      endcase
      // Byte 0 carries I_id as sampled here; the serializer holds it from
      // then on, so later I_id changes cannot reach this frame.
      if (start_frame) begin
        state_d    = ST_FRAME;
        byte_idx_d = 4'd0;
        aux_d      = 8'h00;
        load_byte  = {I_id, 1'b1};
      end
      // Any sync restarts the count of frames toward the forced sync.
      if (start_sync) begin
        state_d    = ST_SYNC;
        byte_idx_d = 4'd0;
        interval_d = 8'd0;
        load_byte  = SYNC_BYTE;
      end
    end
  end

  // State registers; activity flags move in step with the serializer output.
  always_ff @(posedge trace_clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SYNC;
      byte_idx_q     <= 4'd0;
      aux_q          <= 8'h00;
      interval_q     <= 8'd0;
      count_q        <= 16'd0;
      sync_active_q  <= 1'b1;
      frame_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_idx_q     <= byte_idx_d;
      aux_q          <= aux_d;
      interval_q     <= interval_d;
      count_q        <= count_d;
      sync_active_q  <= (state_d == ST_SYNC);
      frame_active_q <= (state_d != ST_SYNC);
    end
  end

  tpiu_nibble_ser u_ser (
    .trace_clk   (trace_clk),
    .reset       (reset),
    .load        (load),
    .byte_in     (load_byte),
    .nibble      (O_tracedata),
    .last_nibble (last_nibble)
  );

  assign O_sync_active  = sync_active_q;
  assign O_frame_active = frame_active_q;
  assign O_frame_count  = count_q;

endmodule

// File: tb/tb_tpiu_trace_tx.sv
// Bench for tpiu_trace_tx: a frame-level model of the output stream is
// checked every cycle, and decoded frames are pinned against literal bytes.
module tb_tpiu_trace_tx;

  localparam int P_SYNC = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        trace_clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  I_id = 7'd0;
  logic [7:0]  I_data = 8'd0;
  logic        I_valid = 1'b0;
  logic        O_ready;
  logic [3:0]  O_tracedata;
  logic        O_sync_active;
  logic        O_frame_active;
  logic [15:0] O_frame_count;

  always #5 trace_clk = ~trace_clk;

  tpiu_trace_tx #(.pSYNC_FRAMES(P_SYNC)) dut (
    .trace_clk      (trace_clk),
    .reset          (reset),
    .I_id           (I_id),
    .I_data         (I_data),
    .I_valid        (I_valid),
    .O_ready        (O_ready),
    .O_tracedata    (O_tracedata),
    .O_sync_active  (O_sync_active),
    .O_frame_active (O_frame_active),
    .O_frame_count  (O_frame_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The stream is a sequence of units: an 8-nibble sync or a 32-nibble
  // frame. m_rel is the nibble position inside the current unit.
  int          m_rel;
  bit          m_in_frame;
  logic [6:0]  m_id;
  logic [7:0]  m_raw [16];
  int          m_pad_from;
  int          m_since;
  logic [15:0] m_count;
  logic [7:0]  tx_q [$];

  task automatic model_reset();
    m_rel = 0; m_in_frame = 0; m_id = 7'd0; m_pad_from = 16;
    m_since = 0; m_count = 16'd0;
  endtask

  function automatic logic [7:0] byte_of(input int j);
    logic [7:0] aux;
    if (!m_in_frame) return (j == 3) ? 8'h7F : 8'hFF;
    if (j == 0) return {m_id, 1'b1};
    if (j == 15) begin
      aux = 8'h00;
      for (int i = 1; i < 8; i++)
        if (2 * i < m_pad_from) aux[i] = m_raw[2 * i][0];
      return aux;
    end
    if (j >= m_pad_from) return (j % 2 == 0) ? 8'h01 : 8'h00;
    return (j % 2 == 1) ? m_raw[j] : {m_raw[j][7:1], 1'b0};
  endfunction

  function automatic logic m_ready();
    return m_in_frame && (m_pad_from == 16) && (m_rel % 2 == 1) && (m_rel / 2 <= 13);
  endfunction

  // One rising edge of the stream, using the inputs presented to it.
  task automatic model_step();
    int k;
    if (m_ready()) begin
      k = m_rel / 2 + 1;
      if (I_valid) begin
        m_raw[k] = I_data;
        void'(tx_q.pop_front());
      end else begin
        m_pad_from = k;
      end
    end
    if (m_rel == (m_in_frame ? 31 : 7)) begin
      if (m_in_frame) begin
        m_count++;
        m_since++;
      end
      if ((m_in_frame && m_since >= P_SYNC) || !I_valid) begin
        m_in_frame = 0;
        m_since = 0;
      end else begin
        m_in_frame = 1;
        m_id = I_id;
        m_pad_from = 16;
      end
      m_rel = 0;
    end else begin
      m_rel++;
    end
  endtask

  // ---------------- compare process + frame capture ----------------
  bit         cmp_en = 0;
  int         cap_nib = 0;
  int         cap_frames = 0;
  int         sync_units = 0;
  logic [7:0] cap_cur [16];
  logic [7:0] cap_frame [16];

  initial begin
    logic [7:0] eb;
    forever begin
      @(negedge trace_clk);
      if (cmp_en) begin
        eb = byte_of(m_rel / 2);
        chk("tracedata", 16'(O_tracedata), 16'((m_rel % 2 == 1) ? eb[7:4] : eb[3:0]));
        chk("ready", 16'(O_ready), 16'(m_ready()));
        chk("sync_active", 16'(O_sync_active), 16'(!m_in_frame));
        chk("frame_active", 16'(O_frame_active), 16'(m_in_frame));
        chk("frame_count", O_frame_count, m_count);
      end
      if (O_frame_active && !reset) begin
        if (cap_nib % 2 == 0) cap_cur[cap_nib / 2][3:0] = O_tracedata;
        else                  cap_cur[cap_nib / 2][7:4] = O_tracedata;
        cap_nib++;
        if (cap_nib == 32) begin
          cap_frame = cap_cur;
          cap_frames++;
          cap_nib = 0;
        end
      end else begin
        cap_nib = 0;
      end
      if (O_sync_active && O_tracedata == 4'h7) sync_units++;
    end
  end

  // ---------------- driver tasks ----------------
  int valid_mode = 0;  // 0: idle, 1: valid while data queued, 2: random valid
  bit id_rand = 0;

  task automatic drive();
    if (id_rand) I_id = 7'($urandom_range(0, 127));
    if (tx_q.size() == 0)      I_valid = 1'b0;
    else if (valid_mode == 1)  I_valid = 1'b1;
    else if (valid_mode == 2)  I_valid = ($urandom_range(0, 3) != 0);
    else                       I_valid = 1'b0;
    I_data = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom_range(0, 255));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle();
    drive();
    @(posedge trace_clk);
    if (!reset) model_step();
    @(negedge trace_clk);
    #1;
  endtask

  task automatic run_until_frames(input int target, input int budget, input string name);
    int n = 0;
    while (cap_frames < target && n < budget) begin
      cycle();
      n++;
    end
    if (cap_frames < target) fail_timeout(name);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tracedata"}, 16'(O_tracedata), 16'hF);
    chk({tag, "_ready"}, 16'(O_ready), 16'h0);
    chk({tag, "_sync_active"}, 16'(O_sync_active), 16'h1);
    chk({tag, "_frame_active"}, 16'(O_frame_active), 16'h0);
    chk({tag, "_frame_count"}, O_frame_count, 16'h0);
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] exp_full [16];
  logic [7:0] exp_stall [16];
  logic [3:0] obs [16];

  initial begin
    int base, sbase, n;
    exp_full  = '{8'h25, 8'h00, 8'h00, 8'h02, 8'h02, 8'h04, 8'h04, 8'h06,
                  8'h06, 8'h08, 8'h08, 8'h0A, 8'h0A, 8'h0C, 8'h0C, 8'hFE};
    exp_stall = '{8'h25, 8'hA1, 8'hA2, 8'hA2, 8'hA4, 8'h00, 8'h01, 8'h00,
                  8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02};

    // Power-on reset.
    #1 reset = 1'b1;
    model_reset();
    @(negedge trace_clk);
    #1;
    chk_reset_values("por");
    cmp_en = 1;
    cycle();
    cycle();
    reset = 1'b0;

    // Idle: continuous F,F,F,F,F,F,F,7 with nothing offered.
    for (int i = 0; i < 16; i++) begin
      obs[i] = O_tracedata;
      cycle();
    end
    for (int i = 0; i < 16; i++)
      chk("idle_nibble", 16'(obs[i]), (i % 8 == 7) ? 16'h7 : 16'hF);
    chk("idle_count", O_frame_count, 16'd0);

    // Full frame with payload 00..0D, then four more frames back to back.
    I_id = 7'h12;
    for (int i = 0; i < 70; i++) tx_q.push_back(8'(i));
    valid_mode = 1;
    base = cap_frames;
    run_until_frames(base + 1, 200, "full_frame_wait");
    for (int i = 0; i < 16; i++) chk("full_frame_byte", 16'(cap_frame[i]), 16'(exp_full[i]));
    cycle();
    chk("full_frame_count", O_frame_count, 16'd1);

    // Sync interval of 2: frame2, sync, frame3, frame4, sync, frame5.
    sbase = sync_units;
    run_until_frames(base + 5, 400, "interval_wait");
    chk("interval_syncs", 16'(sync_units - sbase), 16'd2);
    cycle();
    chk("interval_count", O_frame_count, 16'd5);

    // Stall after four bytes: the rest of the frame is padding.
    tx_q.push_back(8'hA1); tx_q.push_back(8'hA3);
    tx_q.push_back(8'hA2); tx_q.push_back(8'hA4);
    base = cap_frames;
    run_until_frames(base + 1, 200, "stall_wait");
    for (int i = 0; i < 16; i++) chk("stall_frame_byte", 16'(cap_frame[i]), 16'(exp_stall[i]));
    cycle();
    chk("stall_count", O_frame_count, 16'd6);

    // Random valid and random I_id against the model.
    for (int i = 0; i < 60; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    valid_mode = 2;
    id_rand = 1;
    n = 0;
    while (tx_q.size() > 0 && n < 6000) begin
      cycle();
      n++;
    end
    if (tx_q.size() > 0) fail_timeout("random_drain");
    id_rand = 0;
    valid_mode = 1;
    for (int i = 0; i < 40; i++) cycle();

    // Reset asserted on byte 7 of a frame, then a fresh sync and new ID.
    I_id = 7'h35;
    for (int i = 0; i < 40; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    n = 0;
    while (!(O_frame_active && cap_nib == 14) && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) fail_timeout("reset_point_wait");
    drive();
    @(posedge trace_clk);
    model_step();
    #2 reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    model_reset();
    @(negedge trace_clk);
    #1;
    I_id = 7'h5A;
    cycle();
    reset = 1'b0;
    sbase = sync_units;
    base = cap_frames;
    run_until_frames(base + 1, 200, "post_reset_wait");
    chk("post_reset_syncs", 16'(sync_units - sbase), 16'd1);
    chk("post_reset_id_byte", 16'(cap_frame[0]), 16'hB5);
    valid_mode = 0;
    for (int i = 0; i < 10; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
